// File: rtl/sd_drive_arbiter_pkg.sv
// Shared sizing and state type for the two-drive SD arbiter.
// Covers both builds, with and without SD_ARB_TIMEOUT_EN.
package sd_arb_pkg;

  localparam int NUM_DRIVES = 2;
  localparam int LBA_W      = 32;
  localparam int BUFF_AW    = 9;
  localparam int BUFF_DW    = 8;
  localparam int TMO_W      = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_DONE
  } arb_state_t;

endpackage

// File: rtl/sd_drive_arbiter_if.sv
// Host-side bundle between the arbiter (master) and the SD IO controller (slave).
interface sd_drive_arbiter_if;
  import sd_arb_pkg::*;

  logic [LBA_W-1:0]   lba;
  logic               rd;
  logic               wr;
  logic               ack;
  logic [BUFF_AW-1:0] buff_addr;
  logic [BUFF_DW-1:0] buff_dout;
  logic               buff_wr;
  logic [BUFF_DW-1:0] buff_din;

  modport master (
    output lba, rd, wr, buff_din,
    input  ack, buff_addr, buff_dout, buff_wr
  );

  modport slave (
    input  lba, rd, wr, buff_din,
    output ack, buff_addr, buff_dout, buff_wr
  );

endinterface

// File: rtl/sd_drive_arbiter_rr.sv
// Two-way round-robin picker: returns the index of the drive to serve next.
module rr_arbiter
  import sd_arb_pkg::*;
(
  input  logic [NUM_DRIVES-1:0] req,
  input  logic                  last,
  output logic                  grant,
  output logic                  valid
);

  assign valid = |req;

  // On a tie the drive that was not served last wins.
  assign grant = (&req) ? ~last : req[1];

endmodule

// File: rtl/sd_drive_arbiter.sv
// Shares one SD IO controller between two virtual drives.
// Optional ack watchdog is enabled with the SD_ARB_TIMEOUT_EN macro.
module sd_drive_arbiter
  import sd_arb_pkg::*;
#(
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LBA_W-1:0]   d0_lba,
  input  logic               d0_rd,
  input  logic               d0_wr,
  output logic               d0_ack,
  output logic [BUFF_AW-1:0] d0_buff_addr,
  output logic [BUFF_DW-1:0] d0_buff_dout,
  output logic               d0_buff_wr,
  input  logic [BUFF_DW-1:0] d0_buff_din,
  input  logic [LBA_W-1:0]   d1_lba,
  input  logic               d1_rd,
  input  logic               d1_wr,
  output logic               d1_ack,
  output logic [BUFF_AW-1:0] d1_buff_addr,
  output logic [BUFF_DW-1:0] d1_buff_dout,
  output logic               d1_buff_wr,
  input  logic [BUFF_DW-1:0] d1_buff_din,
  sd_drive_arbiter_if.master sd,
  output logic               sd_drive,
  output logic               busy,
  output logic               timeout_err
);

  arb_state_t            state;
  logic                  last_grant;
  logic [NUM_DRIVES-1:0] req;
  logic                  pick;
  logic                  pick_valid;
  logic                  pick_rd;
  logic                  pick_wr;

  assign req     = {d1_rd | d1_wr, d0_rd | d0_wr};
  assign pick_rd = pick ? d1_rd : d0_rd;
  assign pick_wr = pick ? d1_wr : d0_wr;

  rr_arbiter u_rr (
    .req   (req),
    .last  (last_grant),
    .grant (pick),
    .valid (pick_valid)
  );

`ifdef SD_ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT_CYCLES - TMO_W'(1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || state != ST_REQ) tmo_cnt <= '0;
    else                             tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`else
  // The limit has no effect when the watchdog is compiled out.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sd.rd      <= 1'b0;
      sd.wr      <= 1'b0;
      sd.lba     <= '0;
      busy       <= 1'b0;
      sd_drive   <= 1'b0;
      last_grant <= 1'b1;
`ifdef SD_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // A lingering ack from an interrupted transfer blocks new grants.
          if (pick_valid && !sd.ack) begin
            sd_drive   <= pick;
            last_grant <= pick;
            busy       <= 1'b1;
            sd.lba     <= pick ? d1_lba : d0_lba;
            sd.wr      <= pick_wr;
            sd.rd      <= pick_rd & ~pick_wr;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (sd.ack) begin
            sd.rd <= 1'b0;
            sd.wr <= 1'b0;
            state <= ST_XFER;
          end
`ifdef SD_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            sd.rd       <= 1'b0;
            sd.wr       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_DONE;
          end
`endif
        end
        ST_XFER: begin
          if (!sd.ack) begin
            busy  <= 1'b0;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign d0_ack       = sd.ack & busy & ~sd_drive;
  assign d1_ack       = sd.ack & busy & sd_drive;
  assign d0_buff_wr   = sd.buff_wr & busy & ~sd_drive;
  assign d1_buff_wr   = sd.buff_wr & busy & sd_drive;
  assign d0_buff_addr = sd.buff_addr;
  assign d1_buff_addr = sd.buff_addr;
  assign d0_buff_dout = sd.buff_dout;
  assign d1_buff_dout = sd.buff_dout;
  assign sd.buff_din  = sd_drive ? d1_buff_din : d0_buff_din;

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Bench for sd_drive_arbiter: directed scenarios, then randomized transactions
// predicted by a transaction-level model of the drives' request levels.
module tb_sd_drive_arbiter;
  import sd_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] d0_lba, d1_lba;
  logic        d0_rd, d0_wr, d1_rd, d1_wr;
  logic        d0_ack, d1_ack;
  logic [8:0]  d0_buff_addr, d1_buff_addr;
  logic [7:0]  d0_buff_dout, d1_buff_dout;
  logic        d0_buff_wr, d1_buff_wr;
  logic [7:0]  d0_buff_din, d1_buff_din;
  logic        sd_drive, busy, timeout_err;

  sd_drive_arbiter_if sd();

  sd_drive_arbiter #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .d0_lba       (d0_lba),
    .d0_rd        (d0_rd),
    .d0_wr        (d0_wr),
    .d0_ack       (d0_ack),
    .d0_buff_addr (d0_buff_addr),
    .d0_buff_dout (d0_buff_dout),
    .d0_buff_wr   (d0_buff_wr),
    .d0_buff_din  (d0_buff_din),
    .d1_lba       (d1_lba),
    .d1_rd        (d1_rd),
    .d1_wr        (d1_wr),
    .d1_ack       (d1_ack),
    .d1_buff_addr (d1_buff_addr),
    .d1_buff_dout (d1_buff_dout),
    .d1_buff_wr   (d1_buff_wr),
    .d1_buff_din  (d1_buff_din),
    .sd           (sd),
    .sd_drive     (sd_drive),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Request levels each drive currently holds, plus who was served last.
  logic        m_rd  [2];
  logic        m_wr  [2];
  logic [31:0] m_lba [2];
  int          m_last;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus();
    d0_rd  = m_rd[0];
    d0_wr  = m_wr[0];
    d0_lba = m_lba[0];
    d1_rd  = m_rd[1];
    d1_wr  = m_wr[1];
    d1_lba = m_lba[1];
  endtask

  function automatic int predict_winner();
    bit r0, r1;
    r0 = m_rd[0] | m_wr[0];
    r1 = m_rd[1] | m_wr[1];
    if (r0 && r1) return 1 - m_last;
    return r1 ? 1 : 0;
  endfunction

  task automatic new_request(input int d);
    int op;
    op       = int'($urandom_range(0, 2));
    m_rd[d]  = (op != 1);
    m_wr[d]  = (op != 0);
    m_lba[d] = $urandom;
  endtask

  task automatic reset_dut();
    reset_n      = 1'b0;
    sd.ack       = 1'b0;
    sd.buff_wr   = 1'b0;
    sd.buff_addr = '0;
    sd.buff_dout = '0;
    d0_buff_din  = '0;
    d1_buff_din  = '0;
    for (int d = 0; d < 2; d++) begin
      m_rd[d]  = 1'b0;
      m_wr[d]  = 1'b0;
      m_lba[d] = '0;
    end
    apply_stimulus();
    repeat (2) tick();
    reset_n = 1'b1;
    m_last  = 1;
  endtask

  // One full host transaction: wait for grant, ack after a delay, stream strobes, drop ack.
  task automatic run_txn(input string tag, input int ack_delay, input int strobes,
                         input int fixed_din, input bit inject);
    int         w, n;
    bit         exp_wr;
    int         pulses [2];
    logic [7:0] din [2];
    logic [7:0] dout;
    logic [8:0] addr;
    w      = predict_winner();
    exp_wr = m_wr[w];
    n      = 0;
    while (!(sd.rd || sd.wr) && n < 20) begin
      tick();
      n++;
    end
    check_output({tag, " grant"}, 32'(sd.rd | sd.wr), 32'd1);
    check_output({tag, " sd_drive"}, 32'(sd_drive), 32'(w));
    check_output({tag, " sd_lba"}, sd.lba, m_lba[w]);
    check_output({tag, " op"}, 32'({sd.wr, sd.rd}), exp_wr ? 32'd2 : 32'd1);
    check_output({tag, " busy"}, 32'(busy), 32'd1);
    repeat (ack_delay) tick();
    check_output({tag, " op held"}, 32'({sd.wr, sd.rd}), exp_wr ? 32'd2 : 32'd1);
    sd.ack = 1'b1;
    tick();
    check_output({tag, " req cleared"}, 32'({sd.wr, sd.rd}), 32'd0);
    check_output({tag, " drive ack"}, 32'({d1_ack, d0_ack}), (w == 1) ? 32'd2 : 32'd1);
    if (exp_wr) m_wr[w] = 1'b0;
    else        m_rd[w] = 1'b0;
    m_last = w;
    if (inject && !(m_rd[1-w] | m_wr[1-w])) new_request(1 - w);
    apply_stimulus();
    pulses[0] = 0;
    pulses[1] = 0;
    for (int i = 0; i < strobes; i++) begin
      din[0] = 8'($urandom);
      din[1] = 8'($urandom);
      if (fixed_din >= 0) din[w] = 8'(fixed_din);
      addr = 9'(i);
      dout = 8'($urandom);
      d0_buff_din  = din[0];
      d1_buff_din  = din[1];
      sd.buff_addr = addr;
      sd.buff_dout = dout;
      sd.buff_wr   = 1'b1;
      #1;
      pulses[0] += int'(d0_buff_wr);
      pulses[1] += int'(d1_buff_wr);
      check_output({tag, " buff_din"}, 32'(sd.buff_din), 32'(din[w]));
      check_output({tag, " buff_addr"}, 32'({d1_buff_addr, d0_buff_addr}), 32'({addr, addr}));
      check_output({tag, " buff_dout"}, 32'({d1_buff_dout, d0_buff_dout}), 32'({dout, dout}));
      check_output({tag, " xfer ack"}, 32'({d1_ack, d0_ack}), (w == 1) ? 32'd2 : 32'd1);
      tick();
    end
    sd.buff_wr = 1'b0;
    check_output({tag, " granted pulses"}, 32'(pulses[w]), 32'(strobes));
    check_output({tag, " other pulses"}, 32'(pulses[1-w]), 32'd0);
    sd.ack = 1'b0;
    tick();
    check_output({tag, " busy released"}, 32'(busy), 32'd0);
    check_output({tag, " acks low"}, 32'({d1_ack, d0_ack}), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_dut();
    reset_n = 1'b0;
    tick();
    check_output("reset sd_rd", 32'(sd.rd), 32'd0);
    check_output("reset sd_wr", 32'(sd.wr), 32'd0);
    check_output("reset sd_lba", sd.lba, 32'd0);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset sd_drive", 32'(sd_drive), 32'd0);
    check_output("reset timeout_err", 32'(timeout_err), 32'd0);
    check_output("reset acks", 32'({d1_ack, d0_ack}), 32'd0);
    reset_n = 1'b1;

    // Single read from drive 0 with a full 512-byte sector.
    m_rd[0]  = 1'b1;
    m_lba[0] = 32'h0000_001A;
    apply_stimulus();
    tick();
    check_output("t1 latency", 32'(sd.rd), 32'd1);
    run_txn("t1", 3, 512, -1, 1'b0);

    // Simultaneous reads from reset: drive 0 first, then drive 1.
    reset_dut();
    m_rd[0]  = 1'b1;
    m_lba[0] = 32'h0000_0100;
    m_rd[1]  = 1'b1;
    m_lba[1] = 32'h0000_0200;
    apply_stimulus();
    run_txn("t2 first", 1, 2, -1, 1'b0);
    run_txn("t2 second", 2, 2, -1, 1'b0);

    // Drive 1 write with known data.
    m_wr[1]  = 1'b1;
    m_lba[1] = 32'h0000_3300;
    apply_stimulus();
    run_txn("t3", 1, 4, 8'hA5, 1'b0);

    // Read and write together on drive 0: write goes first.
    m_rd[0]  = 1'b1;
    m_wr[0]  = 1'b1;
    m_lba[0] = 32'h0000_4400;
    apply_stimulus();
    run_txn("t4 write", 0, 2, -1, 1'b0);
    run_txn("t4 read", 1, 2, -1, 1'b0);

    // Reset during a transfer with the host still acking.
    reset_dut();
    m_rd[0]  = 1'b1;
    m_lba[0] = 32'h0000_0500;
    apply_stimulus();
    tick();
    check_output("t5 grant", 32'(sd.rd), 32'd1);
    sd.ack = 1'b1;
    tick();
    m_rd[0]  = 1'b0;
    m_rd[1]  = 1'b1;
    m_lba[1] = 32'h0000_0B0B;
    apply_stimulus();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_last  = 1;
    check_output("t5 busy", 32'(busy), 32'd0);
    check_output("t5 req", 32'({sd.wr, sd.rd}), 32'd0);
    check_output("t5 lba", sd.lba, 32'd0);
    check_output("t5 acks", 32'({d1_ack, d0_ack}), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output("t5 no grant", 32'({sd.wr, sd.rd, busy}), 32'd0);
    end
    sd.ack = 1'b0;
    run_txn("t5 pending", 2, 3, -1, 1'b0);

`ifdef SD_ARB_TIMEOUT_EN
    reset_dut();
    m_rd[0]  = 1'b1;
    m_lba[0] = 32'h0000_0077;
    apply_stimulus();
    tick();
    check_output("tmo grant", 32'(sd.rd), 32'd1);
    repeat (99) tick();
    check_output("tmo rd before limit", 32'(sd.rd), 32'd1);
    tick();
    check_output("tmo rd dropped", 32'(sd.rd), 32'd0);
    check_output("tmo err", 32'(timeout_err), 32'd1);
    check_output("tmo busy", 32'(busy), 32'd0);
    m_last = 0;
    run_txn("tmo next", 1, 2, -1, 1'b0);
    check_output("tmo err sticky", 32'(timeout_err), 32'd1);
`else
    check_output("no timeout err", 32'(timeout_err), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int t = 0; t < 30; t++) begin
      for (int d = 0; d < 2; d++)
        if (!(m_rd[d] | m_wr[d]) && $urandom_range(0, 1) == 1) new_request(d);
      if (!(m_rd[0] | m_wr[0] | m_rd[1] | m_wr[1])) new_request(int'($urandom_range(0, 1)));
      apply_stimulus();
      run_txn("rand", int'($urandom_range(0, 4)), int'($urandom_range(1, 6)), -1,
              1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_drive_arbiter.md
SD_DRIVE_ARBITER -- requirements
Module: sd_drive_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 24'd12_000_000, ack-wait limit in clk cycles (used only with SD_ARB_TIMEOUT_EN).
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 dN_lba  in  32  drive N (N=0,1) sector address, sampled at grant.
REQ-005 dN_rd / dN_wr  in  1 each  drive N read/write request levels, held until dN_ack seen high.
REQ-006 dN_ack  out  1  copy of sd_ack while drive N is granted, else 0.
REQ-007 dN_buff_addr  out  9  copy of sd_buff_addr (broadcast).
REQ-008 dN_buff_dout  out  8  copy of sd_buff_dout (broadcast).
REQ-009 dN_buff_wr  out  1  sd_buff_wr gated by grant N.
REQ-010 dN_buff_din  in  8  drive N write data toward the SD host.
REQ-011 sd_lba  out  32  latched LBA of the granted request.
REQ-012 sd_rd / sd_wr  out  1 each  request to the IO controller.
REQ-013 sd_ack  in  1  IO controller acknowledge; sd_buff_addr in 9, sd_buff_dout in 8, sd_buff_wr in 1, sd_buff_din out 8.
REQ-014 sd_drive  out  1  index of current grant (valid while busy); busy out 1; timeout_err out 1.

Function
REQ-015 States: IDLE, REQ (rd/wr driven, waiting for ack rise), XFER (ack high), DONE (ack fallen, one-cycle release).
REQ-016 IDLE: if any dN_rd|dN_wr and sd_ack=0, register grant, sd_lba, sd_rd/sd_wr and busy=1 on the next edge (1-cycle latency), go REQ.
REQ-017 Two drives requesting in the same cycle: round-robin, drive not granted last wins; after reset drive 0 wins first.
REQ-018 dN_rd and dN_wr both high: write served first (sd_wr=1, sd_rd=0).
REQ-019 REQ: on sd_ack=1 clear sd_rd/sd_wr on that edge, go XFER.
REQ-020 XFER: sd_buff_din = granted dN_buff_din (combinational mux); on sd_ack=0 go DONE.
REQ-021 DONE: busy=0, grant released, return IDLE; new grant earliest the following cycle.
REQ-022 Requests from the non-granted drive stay pending (not lost) until served.
REQ-023 Granted drive deasserting its request before ack: request to host still completes; transfer treated as normal.
REQ-024 Never assert sd_rd and sd_wr together; never grant while sd_ack=1.

Reset
REQ-025 reset_n=0: sd_rd=0, sd_wr=0, sd_lba=0, busy=0, sd_drive=0, timeout_err=0, state IDLE, last-grant=1 (so drive 0 first).
REQ-026 Reset mid-transfer: outputs cleared as above; if sd_ack still high after reset, stay IDLE until it drops.

Configuration
REQ-027 Macro SD_ARB_TIMEOUT_EN defined: 24-bit counter runs in REQ; reaching TIMEOUT_CYCLES clears sd_rd/sd_wr, sets timeout_err sticky (cleared only by reset), goes DONE.
REQ-028 Macro undefined: no counter, timeout_err tied 0, REQ waits indefinitely.

Structure
REQ-029 Package sd_arb_pkg: state enum type, NUM_DRIVES=2, LBA_W=32, BUFF_AW=9, timeout counter width.
REQ-030 One sub-module rr_arbiter: 2-way round-robin picker (req[1:0], last, grant index, valid).

Verification
REQ-031 d0_rd=1, d0_lba=0x1A, ack rises 3 cycles later, 512 buff_wr strobes, ack falls -> sd_rd=1 cycle after request, sd_lba=0x1A, only d0_buff_wr pulses 512 times, busy=0 one cycle after ack fall.
REQ-032 d0_rd and d1_rd same cycle from reset -> drive 0 served, then drive 1 with d1_lba, sd_drive 0 then 1.
REQ-033 d1_wr with d1_buff_din=0xA5 -> sd_wr=1, sd_buff_din=0xA5 during XFER, d0_ack stays 0.
REQ-034 d0_rd and d0_wr both high -> sd_wr first, then sd_rd on next grant.
REQ-035 reset_n pulsed low during XFER with sd_ack held high 10 more cycles, d1_rd pending -> no grant until ack low, then drive 0 priority reset, d1 granted.
REQ-036 SD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, no ack -> sd_rd drops at cycle 100, timeout_err=1, next request still granted.
